// File: rtl/keccak_unpadder.sv
// Keccak pad10*1 receive-side unpadder.
// Non-final rate blocks pass straight through. The final block is buffered and
// scanned from its last word backwards to locate the 0x01 pad byte. Only message
// words are then re-emitted, with a byte count on the last one and a flag for
// malformed padding.
module keccak_unpadder #(
  parameter int unsigned IW = 64,  // word width, 64 or 128
  parameter int unsigned RW = 9,   // words per rate block
  parameter int unsigned BW = 4    // out_bytes width, must hold IW/8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last_block,
  output logic          in_ready,
  output logic [IW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [BW-1:0] out_bytes,
  output logic          pad_err
);

  localparam int unsigned NB = IW / 8;
  localparam int unsigned CW = (RW > 1) ? $clog2(RW) : 1;
  localparam logic [CW-1:0] LastW = CW'(RW - 1);

  typedef enum logic [1:0] {StPass, StFill, StScan, StEmit} state_e;

  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_wcnt, w_wcnt_nxt;
  logic [CW-1:0] r_idx, w_idx_nxt;
  logic [CW-1:0] r_lastidx, w_lastidx_nxt;
  logic [CW-1:0] r_ecnt, w_ecnt_nxt;
  logic [BW-1:0] r_nbytes, w_nbytes_nxt;
  logic          r_err, w_err_nxt;
  logic [IW-1:0] r_buf [RW];
  logic          w_buf_we;

  logic [IW-1:0] w_eff;
  logic          w_eff_nz;
  logic [BW-1:0] w_p;
  logic [7:0]    w_pbyte;
  logic [IW-1:0] w_mask;
  logic          w_emit_last;

  // Scan datapath: effective word under idx and its least-significant nonzero byte.
  always_comb begin
    w_eff = r_buf[r_idx];
    // Final pad bit lives in bit 7 of the last word; strip it before searching.
    if (r_idx == LastW) w_eff[7] = 1'b0;
    w_eff_nz = |w_eff;
    w_p      = '0;
    w_pbyte  = '0;
    for (int i = 0; i < int'(NB); i++) begin
      if (w_eff[IW-1-8*i -: 8] != 8'h00) begin
        w_p     = BW'(i);
        w_pbyte = w_eff[IW-1-8*i -: 8];
      end
    end
  end

  // Byte mask keeping the first r_nbytes bytes (MSB-first) of the last word.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(NB); i++) begin
      w_mask[IW-1-8*i -: 8] = (i < int'(r_nbytes)) ? 8'hFF : 8'h00;
    end
  end

  // Next-state, handshake and output decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_wcnt_nxt    = r_wcnt;
    w_idx_nxt     = r_idx;
    w_lastidx_nxt = r_lastidx;
    w_ecnt_nxt    = r_ecnt;
    w_nbytes_nxt  = r_nbytes;
    w_err_nxt     = r_err;
    w_buf_we      = 1'b0;
    w_emit_last   = 1'b0;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    out_last      = 1'b0;
    out_bytes     = '0;
    pad_err       = 1'b0;

    unique case (r_state)
      StPass: begin
        if (r_wcnt == '0 && in_last_block) begin
          // Final block starts: swallow it into the buffer.
          in_ready = 1'b1;
          if (in_valid) begin
            w_buf_we    = 1'b1;
            w_wcnt_nxt  = CW'(1);
            w_state_nxt = StFill;
          end
        end else begin
          in_ready  = out_ready;
          out_valid = in_valid;
          // Idle outputs stay zero so the bus is quiet between words.
          if (in_valid) begin
            out_data  = in_data;
            out_bytes = BW'(NB);
          end
          if (in_valid && out_ready) begin
            w_wcnt_nxt = (r_wcnt == LastW) ? '0 : r_wcnt + 1'b1;
          end
        end
      end

      StFill: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_buf_we = 1'b1;
          if (r_wcnt == LastW) begin
            w_wcnt_nxt  = '0;
            w_idx_nxt   = LastW;
            w_state_nxt = StScan;
          end else begin
            w_wcnt_nxt = r_wcnt + 1'b1;
          end
        end
      end

      StScan: begin
        if (r_idx == LastW && !r_buf[LastW][7]) w_err_nxt = 1'b1;
        if (!w_eff_nz) begin
          if (r_idx == '0) begin
            // No marker anywhere: report an empty, erroneous message.
            w_err_nxt     = 1'b1;
            w_lastidx_nxt = '0;
            w_nbytes_nxt  = '0;
            w_ecnt_nxt    = '0;
            w_state_nxt   = StEmit;
          end else begin
            w_idx_nxt = r_idx - 1'b1;
          end
        end else begin
          if (w_pbyte != 8'h01) w_err_nxt = 1'b1;
          if (w_p != '0) begin
            w_lastidx_nxt = r_idx;
            w_nbytes_nxt  = w_p;
          end else if (r_idx != '0) begin
            // Marker opens a word: message ended on the previous word boundary.
            w_lastidx_nxt = r_idx - 1'b1;
            w_nbytes_nxt  = BW'(NB);
          end else begin
            w_lastidx_nxt = '0;
            w_nbytes_nxt  = '0;
          end
          w_ecnt_nxt  = '0;
          w_state_nxt = StEmit;
        end
      end

      StEmit: begin
        w_emit_last = (r_ecnt == r_lastidx);
        out_valid   = 1'b1;
        out_last    = w_emit_last;
        out_data    = w_emit_last ? (r_buf[r_ecnt] & w_mask) : r_buf[r_ecnt];
        out_bytes   = w_emit_last ? r_nbytes : BW'(NB);
        pad_err     = w_emit_last & r_err;
        if (out_ready) begin
          if (w_emit_last) begin
            w_wcnt_nxt  = '0;
            w_err_nxt   = 1'b0;
            w_state_nxt = StPass;
          end else begin
            w_ecnt_nxt = r_ecnt + 1'b1;
          end
        end
      end

      default: w_state_nxt = StPass;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StPass;
      r_wcnt    <= '0;
      r_idx     <= '0;
      r_lastidx <= '0;
      r_ecnt    <= '0;
      r_nbytes  <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_wcnt    <= w_wcnt_nxt;
      r_idx     <= w_idx_nxt;
      r_lastidx <= w_lastidx_nxt;
      r_ecnt    <= w_ecnt_nxt;
      r_nbytes  <= w_nbytes_nxt;
      r_err     <= w_err_nxt;
    end
  end

  // Final-block buffer, written at the current word position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(RW); i++) r_buf[i] <= '0;
    end else if (w_buf_we) begin
      r_buf[r_wcnt] <= in_data;
    end
  end

endmodule

// File: doc/keccak_unpadder.md
Name: keccak_unpadder

Overview:
- Receive side of the Keccak sponge padding scheme used with the 64-bit-word padder.
- Takes a stream of rate-sized blocks and passes non-final blocks through unchanged.
- Buffers the final block and scans it backwards to locate the pad-10*1 marker.
- Re-emits only the message words, with a valid-byte count on the last word, and flags malformed padding.

Parameters:
- IW, 64, word width in bits; only 64 and 128 are supported.
- RW, 9, words per rate block (Keccak-512 rate is 576 bits, i.e. 9×64).
- BW, 4, width of out_bytes; must hold IW/8.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- in_data  in  IW  padded block word; message byte 0 sits in in_data[IW-1:IW-8].
- in_valid  in  1  in_data is valid.
- in_last_block  in  1  current block is the final (padded) block; held constant for all RW words of the block.
- in_ready  out  1  block accepts a word.
- out_data  out  IW  message word; bytes beyond out_bytes are forced to 0.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts a word.
- out_last  out  1  current word is the last word of the message.
- out_bytes  out  BW  number of valid bytes, MSB-first; always IW/8 unless out_last is set.
- pad_err  out  1  malformed padding; asserted together with out_last.

Behaviour:
- Reset values: out_valid=0, out_last=0, out_bytes=0, pad_err=0, out_data=0, state=PASS, word counter wcnt=0.
- Handshake: a transfer occurs when valid && ready; out_data, out_last, out_bytes and pad_err are stable while out_valid=1 && !out_ready.
- PASS state:
  - If in_last_block=0: combinational pass-through. out_valid=in_valid, in_ready=out_ready, out_data=in_data, out_bytes=IW/8, out_last=0. wcnt advances on each transfer and wraps from RW-1 to 0.
  - If in_last_block=1 at wcnt=0: in_ready=1 and out_valid=0. The first word is written to buf[0] and the block enters FILL.
- FILL state: in_ready=1. Each transfer writes buf[wcnt]. The transfer at wcnt=RW-1 moves to SCAN with idx=RW-1.
- SCAN state: in_ready=0, out_valid=0. One word per cycle, idx decrements.
  - Effective word is buf[idx]; when idx=RW-1, bit 7 is cleared from it first.
  - Also at idx=RW-1: if buf[RW-1][7]=0, set err.
  - If the effective word is all zero: if idx=0, set err and go to EMIT with lastidx=0, nbytes=0; otherwise idx--.
  - Otherwise, let p be the highest byte index with a nonzero byte (byte 0 = MSB byte).
    - If byte p != 8'h01, set err.
    - If p>0: lastidx=idx, nbytes=p.
    - If p=0 and idx>0: lastidx=idx-1, nbytes=IW/8.
    - If p=0 and idx=0: lastidx=0, nbytes=0 (empty tail).
    - Then go to EMIT.
  - Latency: RW-lastidx scan cycles, or RW-idx_found when the marker is found in a word.
- EMIT state: out_valid=1, emitting buf[0..lastidx] in order.
  - Non-final words: out_bytes=IW/8, out_last=0.
  - Word lastidx: out_last=1, out_bytes=nbytes, data masked to nbytes, pad_err=err.
  - Empty tail emits one word: out_data=0, out_bytes=0, out_last=1.
  - After the last transfer: go to PASS, wcnt=0, err cleared.
- Non-final blocks carry no padding checks.
- in_last_block toggling mid-block is ignored; it is sampled only at wcnt=0.
- Reset mid-operation discards the buffer and any partial block, and returns to PASS.
- out_ready=0 during EMIT stalls the output; there is no data loss.

Test Plan:
- Short final block. IW=64, RW=9, one final block: word0=64'hAABBCC01_00000000, words1-7=0, word8=64'h80. Required: 9 scan cycles, then one output word 64'hAABBCC00_00000000 with out_bytes=3, out_last=1, pad_err=0.
- 71-byte final block. Words 0-7 full, word8=64'h11223344_55667781. Required: 9 words out, the last being 64'h11223344_55667700 with out_bytes=7, out_last=1; scan takes 1 cycle.
- Word-aligned message. 64 message bytes: word8=64'h01000000_00000080. Required: 8 words out, word7 has out_bytes=8 and out_last=1.
- Empty tail and pass-through. A non-final block of 9 words followed by a final block with word0=64'h01000000_00000000, word8=64'h80.
  - Required: 9 pass-through words at zero latency with out_bytes=8.
  - Then a single word with out_data=0, out_bytes=0, out_last=1.
- Malformed padding, two cases:
  - word8=64'h0 with marker 8'h01 elsewhere → pad_err=1 on the out_last word.
  - word0=64'hAA020000_00000000, word8=64'h80 → pad_err=1, out_bytes=1.
- Backpressure and reset:
  - Toggle out_ready 1-0 randomly during EMIT → outputs stable while stalled and the word sequence is intact.
  - Assert Reset during SCAN → all outputs return to 0, and the next non-final block passes through correctly.
